uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
Parametrised UART program loader. It succeeds the fixed 16-bit UART RAM loader.
- Receives 8N1 bytes on rx and assembles them little-endian into WORD_BYTES-wide instruction words.
- Writes those words sequentially into an internal 2^ADDR_W-deep program memory while in load mode.
- In run mode, serves registered reads to the CPU fetch path.
- Adds false-start rejection, framing-error detection, partial-word timeout, a full flag and a word counter. Memory does not wrap.

Parameters:
CLKS_PER_BIT, 234, clk cycles per UART bit (≥ 4); counter widths derived via $clog2
WORD_BYTES, 2, bytes per memory word; word width DW = 8*WORD_BYTES
ADDR_W, 8, memory address width; depth = 2^ADDR_W
TIMEOUT_BITS, 20, idle bit-periods after which a partially assembled word is discarded

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx  input  1  UART serial input, idle high, asynchronous
button  input  1  mode-toggle pushbutton, active-low, asynchronous
rd_addr  input  ADDR_W  run-mode fetch address
rd_data  output  DW  registered memory read data
mode  output  1  0 = load mode, 1 = run mode
word_count  output  ADDR_W+1  words written since last load-mode entry
full  output  1  memory full; further words dropped
frame_err  output  1  sticky framing-error flag

Behaviour:
- Reset (async, active-high) sets:
  - rx and button synchronisers to 1.
  - FSM to IDLE; byte index to 0; write address to 0.
  - mode = 0, word_count = 0, full = 0, frame_err = 0, rd_data = 0.
  - Memory contents are not reset.
  - Reset mid-frame aborts the frame; any partial word is lost.
- rx and button each pass through a 2-FF synchroniser. All logic uses only the synchronised versions.
- A synchronised button falling edge toggles mode, once per edge.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge on synchronised rx goes to START with the bit counter cleared.
  - START: at counter = CLKS_PER_BIT/2 − 1 (mid start bit), sample rx.
    - If rx = 1: glitch; return to IDLE, no error.
    - Else: clear the counter and go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, i.e. at mid-bit. Shift LSB first. After 8 samples, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles (mid stop bit).
    - If rx = 1: byte_valid pulses for 1 cycle.
    - If rx = 0: set frame_err, drop the byte, clear the byte index (partial word discarded).
    - In both cases go to IDLE.
- Byte assembly occurs only when mode = 0. Bytes completed in run mode are ignored.
  - Byte k of a word lands in bits [8k+7:8k]; the first byte is the LSB.
  - On the WORD_BYTES-th byte_valid, the word is written to mem[wr_addr] at the next clock edge. On that same edge, wr_addr and word_count increment and the byte index returns to 0.
- Full handling:
  - full = 1 when word_count = 2^ADDR_W.
  - While full, completed words are dropped. There is no wrap; wr_addr holds.
- Timeout: while the FSM is in IDLE with byte index ≠ 0, an idle counter runs. Any start detection clears it.
  - On reaching TIMEOUT_BITS*CLKS_PER_BIT cycles, the byte index clears and the partial word is discarded.
  - frame_err is not set by a timeout.
- Load-mode entry (mode 1→0) on the toggle edge clears wr_addr, word_count, full, frame_err and the byte index. Memory is retained.
- Run-mode entry (mode 0→1) freezes all load state.
- A word write is qualified by mode as registered before the clock edge.
  - A toggle to run coincident with a word completion still writes the word.
  - A toggle to load coincident with a word completion: the clear wins and the word is dropped.
- Read path:
  - mode = 1: rd_data <= mem[rd_addr] each cycle (1-cycle latency).
  - mode = 0: rd_data <= 0.

Test Plan:
- CLKS_PER_BIT=16, WORD_BYTES=2, mode=0: send 0x34, 0x12, 0x78, 0x56 → word_count=2. Toggle button, set rd_addr=0 → rd_data=0x1234 one cycle later; rd_addr=1 → 0x5678.
- rx low pulse of 5 clks in IDLE → FSM returns to IDLE, no byte, frame_err=0. Send 0xAA with stop bit forced 0 → frame_err=1, byte index 0. Next two valid bytes form word 0.
- Send one byte 0x11, then idle 20*16 clks, then 0x22, 0x33 → mem[0]=0x3322. 0x11 is discarded.
- ADDR_W=2: send 5 words → full=1 after 4th; word_count=4; mem[0..3] hold the first four words, mem[0] is unchanged by the 5th.
- Toggle to run, send 0xFF, 0xFF → no write, word_count unchanged. Toggle to load → word_count=0, full=0, frame_err=0.
- Assert reset mid-DATA of byte 2 → outputs at reset values. After release, a fresh 2-byte send writes mem[0].

Source files
------------

// File: rtl/uart_prog_loader_if.sv
// Load/fetch port bundle of the UART program loader: serial input, mode button,
// run-mode fetch port and load-status outputs.
interface uart_prog_loader_if #(
    parameter int WORD_BYTES = 2,
    parameter int ADDR_W     = 8
);
    localparam int DW = 8 * WORD_BYTES;

    logic              rx;
    logic              button;
    logic [ADDR_W-1:0] rd_addr;
    logic [DW-1:0]     rd_data;
    logic              mode;
    logic [ADDR_W:0]   word_count;
    logic              full;
    logic              frame_err;

    modport master (
        output rx, button, rd_addr,
        input  rd_data, mode, word_count, full, frame_err
    );

    modport slave (
        input  rx, button, rd_addr,
        output rd_data, mode, word_count, full, frame_err
    );
endinterface

// File: rtl/uart_prog_loader.sv
// 8N1 UART receiver that packs little-endian bytes into program words and writes
// them to an internal memory in load mode; serves registered fetches in run mode.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 234,
    parameter int WORD_BYTES   = 2,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                clk,
    input  logic                reset,
    uart_prog_loader_if.slave   bus
);
    localparam int DW     = 8 * WORD_BYTES;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CW     = $clog2(CLKS_PER_BIT);
    localparam int BI_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int IW     = $clog2(TO_CYC + 1);
    localparam int LASTI  = WORD_BYTES - 1;

    localparam logic [CW-1:0]   HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   BIT_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BI_W-1:0] LAST_B   = BI_W'(LASTI);
    localparam logic [IW-1:0]   TO_M1    = IW'(TO_CYC - 1);
    localparam logic [ADDR_W:0] DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic rx_s1_q, rx_s2_q, rx_s3_q;
    logic bt_s1_q, bt_s2_q, bt_s3_q;
    state_t state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
    logic [DW-1:0]     word_buf_q, word_buf_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              full_q, full_d;
    logic              frame_err_q, frame_err_d;
    logic [IW-1:0]     idle_cnt_q, idle_cnt_d;
    logic              mode_q, mode_d;
    logic [DW-1:0]     rd_data_q, rd_data_d;

    logic          byte_valid, stop_err, mem_we, btn_fall, load_entry;
    logic [DW-1:0] wr_word;
    logic [DW-1:0] mem [DEPTH];

    assign btn_fall   = bt_s3_q & ~bt_s2_q;
    assign load_entry = btn_fall & mode_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rx_s3_q && !rx_s2_q) state_d = S_START;
            end
            S_START: if (cnt_q == HALF_M1) begin
                cnt_d     = '0;
                bit_idx_d = '0;
                state_d   = rx_s2_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (cnt_q == BIT_M1) begin
                cnt_d     = '0;
                shift_d   = {rx_s2_q, shift_q[7:1]};
                bit_idx_d = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) state_d = S_STOP;
            end
            S_STOP: if (cnt_q == BIT_M1) begin
                state_d    = S_IDLE;
                byte_valid = rx_s2_q;
                stop_err   = ~rx_s2_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_word                = word_buf_q;
        wr_word[8*LASTI +: 8]  = shift_q;
    end

    // Load state only advances in load mode; run mode leaves it frozen.
    always_comb begin
        mode_d       = mode_q ^ btn_fall;
        byte_idx_d   = byte_idx_q;
        word_buf_d   = word_buf_q;
        wr_addr_d    = wr_addr_q;
        word_count_d = word_count_q;
        full_d       = full_q;
        frame_err_d  = frame_err_q;
        idle_cnt_d   = idle_cnt_q;
        mem_we       = 1'b0;
        if (!mode_q) begin
            idle_cnt_d = '0;
            if (state_q == S_IDLE && byte_idx_q != '0) begin
                if (idle_cnt_q == TO_M1) byte_idx_d = '0;
                else                     idle_cnt_d = idle_cnt_q + IW'(1);
            end
            if (byte_valid) begin
                word_buf_d[8*byte_idx_q +: 8] = shift_q;
                if (byte_idx_q == LAST_B) begin
                    byte_idx_d = '0;
                    if (!full_q) begin
                        mem_we       = 1'b1;
                        word_count_d = word_count_q + 1'b1;
                        full_d       = (word_count_d == DEPTH_C);
                        if (wr_addr_q != ADDR_MAX) wr_addr_d = wr_addr_q + 1'b1;
                    end
                end else begin
                    byte_idx_d = byte_idx_q + BI_W'(1);
                end
            end
            if (stop_err) begin
                frame_err_d = 1'b1;
                byte_idx_d  = '0;
            end
        end
        if (load_entry) begin
            byte_idx_d   = '0;
            wr_addr_d    = '0;
            word_count_d = '0;
            full_d       = 1'b0;
            frame_err_d  = 1'b0;
            idle_cnt_d   = '0;
        end
        rd_data_d = mode_q ? mem[bus.rd_addr] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_s3_q      <= 1'b1;
            bt_s1_q      <= 1'b1;
            bt_s2_q      <= 1'b1;
            bt_s3_q      <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_idx_q   <= '0;
            word_buf_q   <= '0;
            wr_addr_q    <= '0;
            word_count_q <= '0;
            full_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            idle_cnt_q   <= '0;
            mode_q       <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            rx_s1_q      <= bus.rx;
            rx_s2_q      <= rx_s1_q;
            rx_s3_q      <= rx_s2_q;
            bt_s1_q      <= bus.button;
            bt_s2_q      <= bt_s1_q;
            bt_s3_q      <= bt_s2_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_idx_q   <= byte_idx_d;
            word_buf_q   <= word_buf_d;
            wr_addr_q    <= wr_addr_d;
            word_count_q <= word_count_d;
            full_q       <= full_d;
            frame_err_q  <= frame_err_d;
            idle_cnt_q   <= idle_cnt_d;
            mode_q       <= mode_d;
            rd_data_q    <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr_q] <= wr_word;
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.mode       = mode_q;
    assign bus.word_count = word_count_q;
    assign bus.full       = full_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: 16 clocks per bit, 2-byte words, 4-word memory.
module tb_uart_prog_loader;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_prog_loader_if #(.WORD_BYTES(2), .ADDR_W(2)) bus ();

    uart_prog_loader #(
        .CLKS_PER_BIT(16), .WORD_BYTES(2), .ADDR_W(2), .TIMEOUT_BITS(20)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk); bus.rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (16) @(negedge clk);
        end
        bus.rx = stop;
        repeat (16) @(negedge clk);
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic press_button();
        @(negedge clk); bus.button = 1'b0;
        repeat (4) @(negedge clk);
        bus.button = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic read_word(input logic [1:0] a, output logic [15:0] d);
        @(negedge clk); bus.rd_addr = a;
        repeat (2) @(negedge clk);
        d = bus.rd_data;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.rx = 1'b1; bus.button = 1'b1; bus.rd_addr = '0;
        repeat (5) @(negedge clk);
        n_checks++; if (bus.mode !== 1'b0) begin n_fail++; $display("FAIL reset_mode got %b exp 0", bus.mode); end
        n_checks++; if (bus.word_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.word_count); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", bus.full); end
        n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b exp 0", bus.frame_err); end
        n_checks++; if (bus.rd_data !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", bus.rd_data); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_load_basic();
        logic [15:0] d;
        send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
        send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
        n_checks++; if (bus.word_count !== 3'd2) begin n_fail++; $display("FAIL basic_count got %0d exp 2", bus.word_count); end
        n_checks++; if (bus.rd_data !== 16'h0) begin n_fail++; $display("FAIL basic_load_rdata got %h exp 0", bus.rd_data); end
        press_button();
        n_checks++; if (bus.mode !== 1'b1) begin n_fail++; $display("FAIL basic_mode_run got %b exp 1", bus.mode); end
        read_word(2'd0, d);
        n_checks++; if (d !== 16'h1234) begin n_fail++; $display("FAIL basic_mem0 got %h exp 1234", d); end
        read_word(2'd1, d);
        n_checks++; if (d !== 16'h5678) begin n_fail++; $display("FAIL basic_mem1 got %h exp 5678", d); end
        press_button();
        n_checks++; if (bus.mode !== 1'b0) begin n_fail++; $display("FAIL basic_mode_load got %b exp 0", bus.mode); end
        n_checks++; if (bus.word_count !== 3'd0) begin n_fail++; $display("FAIL basic_count_clr got %0d exp 0", bus.word_count); end
    endtask

    task automatic test_glitch_frame();
        logic [15:0] d;
        @(negedge clk); bus.rx = 1'b0;
        repeat (5) @(negedge clk);
        bus.rx = 1'b1;
        repeat (200) @(negedge clk);
        send_byte(8'h5A, 1'b1);
        n_checks++; if (bus.word_count !== 3'd0) begin n_fail++; $display("FAIL glitch_count got %0d exp 0", bus.word_count); end
        n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_ferr got %b exp 0", bus.frame_err); end
        send_byte(8'hAA, 1'b0);
        n_checks++; if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_err_set got %b exp 1", bus.frame_err); end
        n_checks++; if (bus.word_count !== 3'd0) begin n_fail++; $display("FAIL frame_count got %0d exp 0", bus.word_count); end
        send_byte(8'hCD, 1'b1); send_byte(8'hAB, 1'b1);
        n_checks++; if (bus.word_count !== 3'd1) begin n_fail++; $display("FAIL frame_next_count got %0d exp 1", bus.word_count); end
        press_button();
        read_word(2'd0, d);
        n_checks++; if (d !== 16'hABCD) begin n_fail++; $display("FAIL frame_mem0 got %h exp abcd", d); end
        press_button();
        n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_err_clr got %b exp 0", bus.frame_err); end
    endtask

    task automatic test_timeout();
        logic [15:0] d;
        send_byte(8'h11, 1'b1);
        repeat (330) @(negedge clk);
        send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
        n_checks++; if (bus.word_count !== 3'd1) begin n_fail++; $display("FAIL timeout_count got %0d exp 1", bus.word_count); end
        n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL timeout_ferr got %b exp 0", bus.frame_err); end
        press_button();
        read_word(2'd0, d);
        n_checks++; if (d !== 16'h3322) begin n_fail++; $display("FAIL timeout_mem0 got %h exp 3322", d); end
        press_button();
    endtask

    task automatic test_full_and_run();
        logic [15:0] words [5];
        logic [15:0] d;
        words[0] = 16'hA1B2; words[1] = 16'hC3D4; words[2] = 16'hE5F6;
        words[3] = 16'h0718; words[4] = 16'h2930;
        for (int w = 0; w < 5; w++) begin
            send_byte(words[w][7:0], 1'b1);
            send_byte(words[w][15:8], 1'b1);
            if (w == 2) begin
                n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL full_early got %b exp 0", bus.full); end
            end
            if (w == 3) begin
                n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_set got %b exp 1", bus.full); end
                n_checks++; if (bus.word_count !== 3'd4) begin n_fail++; $display("FAIL full_count4 got %0d exp 4", bus.word_count); end
            end
        end
        n_checks++; if (bus.word_count !== 3'd4) begin n_fail++; $display("FAIL full_count5 got %0d exp 4", bus.word_count); end
        send_byte(8'h00, 1'b0);
        n_checks++; if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL full_ferr got %b exp 1", bus.frame_err); end
        press_button();
        for (int a = 0; a < 4; a++) begin
            read_word(a[1:0], d);
            n_checks++; if (d !== words[a]) begin n_fail++; $display("FAIL full_mem%0d got %h exp %h", a, d, words[a]); end
        end
        send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1);
        n_checks++; if (bus.word_count !== 3'd4) begin n_fail++; $display("FAIL run_count got %0d exp 4", bus.word_count); end
        read_word(2'd0, d);
        n_checks++; if (d !== 16'hA1B2) begin n_fail++; $display("FAIL run_mem0 got %h exp a1b2", d); end
        press_button();
        n_checks++; if (bus.word_count !== 3'd0) begin n_fail++; $display("FAIL reload_count got %0d exp 0", bus.word_count); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reload_full got %b exp 0", bus.full); end
        n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reload_ferr got %b exp 0", bus.frame_err); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        send_byte(8'h55, 1'b1); send_byte(8'h44, 1'b1);
        send_byte(8'h77, 1'b1);
        n_checks++; if (bus.word_count !== 3'd1) begin n_fail++; $display("FAIL rmid_pre_count got %0d exp 1", bus.word_count); end
        @(negedge clk); bus.rx = 1'b0;
        repeat (48) @(negedge clk);
        reset = 1'b1; bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.word_count !== 3'd0) begin n_fail++; $display("FAIL rmid_count got %0d exp 0", bus.word_count); end
        n_checks++; if (bus.mode !== 1'b0) begin n_fail++; $display("FAIL rmid_mode got %b exp 0", bus.mode); end
        n_checks++; if (bus.full !== 1'b0 || bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL rmid_flags got %b%b exp 00", bus.full, bus.frame_err); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'h99, 1'b1); send_byte(8'h88, 1'b1);
        n_checks++; if (bus.word_count !== 3'd1) begin n_fail++; $display("FAIL rmid_post_count got %0d exp 1", bus.word_count); end
        press_button();
        read_word(2'd0, d);
        n_checks++; if (d !== 16'h8899) begin n_fail++; $display("FAIL rmid_mem0 got %h exp 8899", d); end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_glitch_frame();
        test_timeout();
        test_full_and_run();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
